// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its bench.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StDeliver = 2'd2,
    StDone    = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken beq or j, plus the end-of-program test.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter logic [31:0] LAST_PC = 32'd32
) (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] next_pc,
  output logic        out_of_range
);

  logic [31:0] pc4;
  logic [31:0] br_disp;

  always_comb begin
    pc4     = pc + 32'd4;
    br_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    if (jump) begin
      next_pc = {pc4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc4 + br_disp;
    end else begin
      next_pc = pc4;
    end
    out_of_range = (next_pc > LAST_PC) || (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch controller: owns the PC, fetches over req/ack, delivers over valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] LAST_PC  = 32'd32,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr_out,
  output logic [31:0]        instr_pc,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  input  logic               branch_taken,
  input  logic [15:0]        branch_offset,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] retired
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        ipc_q, ipc_d;
  logic [31:0]        next_pc;
  logic               out_of_range;

  next_pc_calc #(
    .LAST_PC (LAST_PC)
  ) u_next_pc_calc (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .out_of_range  (out_of_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      instr_q   <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d      = RESET_PC;
          retired_d = '0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (instr_ready) begin
          if (retired_q != '1) begin
            retired_d = retired_q + COUNT_W'(1);
          end
          // An illegal next PC ends the program with the PC left at the last fetch.
          if (out_of_range) begin
            state_d = StDone;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = pc_q;
    instr_valid = (state_q == StDeliver);
    instr_out   = instr_q;
    instr_pc    = ipc_q;
    busy        = (state_q == StFetch) || (state_q == StDeliver);
    done        = (state_q == StDone);
    retired     = retired_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed step table, corner sequences and random programs.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] LastPc = 32'd32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        busy;
  logic        done;
  logic [15:0] retired;

  int n_checks = 0;
  int n_err    = 0;

  fetch_sequencer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .busy          (busy),
    .done          (done),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          restart;
    int          ack_lat;
    int          rdy_lat;
    bit          j;
    logic [25:0] tgt;
    bit          br;
    logic [15:0] off;
    logic [31:0] exp_addr;
    bit          exp_done;
  } step_t;

  step_t steps[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_req", 32'(imem_req), 32'd1);
    chk("start_addr", imem_addr, 32'd0);
    chk("start_retired", 32'(retired), 32'd0);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Serve one fetch after lat wait cycles; req/addr must hold until ack.
  task automatic serve_fetch(input int lat, input logic [31:0] rdata, input logic [31:0] addr);
    for (int i = 0; i < lat; i++) begin
      chk("fetch_req_wait", 32'(imem_req), 32'd1);
      chk("fetch_addr_wait", imem_addr, addr);
      imem_ack = 1'b0;
      tick();
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("deliver_valid", 32'(instr_valid), 32'd1);
    chk("deliver_instr", instr_out, rdata);
    chk("deliver_pc", instr_pc, addr);
    chk("deliver_req_low", 32'(imem_req), 32'd0);
  endtask

  // Stall for rdy_lat cycles with junk redirect inputs, then accept with the real ones.
  task automatic accept(input int rdy_lat, input bit j, input logic [25:0] tgt, input bit br,
                        input logic [15:0] off, input logic [31:0] exp_instr,
                        input logic [31:0] exp_pc, input bit exp_done, input int exp_ret);
    for (int i = 0; i < rdy_lat; i++) begin
      instr_ready   = 1'b0;
      jump          = 1'($urandom);
      branch_taken  = 1'b1;
      jump_target   = 26'($urandom);
      branch_offset = 16'($urandom);
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr_out, exp_instr);
      chk("stall_pc", instr_pc, exp_pc);
      chk("stall_retired", 32'(retired), 32'(exp_ret - 1));
    end
    instr_ready   = 1'b1;
    jump          = j;
    jump_target   = tgt;
    branch_taken  = br;
    branch_offset = off;
    tick();
    instr_ready   = 1'b0;
    jump          = 1'b0;
    branch_taken  = 1'b0;
    chk("accept_retired", 32'(retired), 32'(exp_ret));
    chk("accept_done", 32'(done), 32'(exp_done));
    chk("accept_busy", 32'(busy), 32'(!exp_done));
    chk("accept_valid_low", 32'(instr_valid), 32'd0);
  endtask

  // Reference next-PC rule from plain arithmetic; returns 1 when the program ends.
  function automatic bit model_next(input logic [31:0] pc, input bit j, input logic [25:0] tgt,
                                    input bit br, input logic [15:0] off,
                                    output logic [31:0] nxt);
    logic [31:0] pc4;
    int          disp;
    pc4  = pc + 32'd4;
    disp = int'($signed(off)) * 4;
    if (j) nxt = (pc4 & 32'hF000_0000) + {4'd0, tgt, 2'b00};
    else if (br) nxt = pc4 + 32'(disp);
    else nxt = pc4;
    return (nxt > LastPc) || (nxt % 4 != 0);
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] nxt;
    int          ret;
    bit          fin;

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_offset = '0;
    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req", 32'(imem_req), 32'd0);

    // Straight-line program: 0..32 then done.
    do_start();
    for (int i = 0; i < 9; i++) begin
      rd = {OP_RTYPE, 26'(i)};
      serve_fetch(0, rd, 32'(i * 4));
      accept(0, 1'b0, '0, 1'b0, '0, rd, 32'(i * 4), i == 8, i + 1);
    end
    chk("seq_retired", 32'(retired), 32'd9);
    tick();
    chk("seq_done_hold", 32'(done), 32'd1);
    chk("seq_retired_hold", 32'(retired), 32'd9);

    steps[0] = '{1'b1, 0, 0, 1'b0, 26'd0, 1'b1, 16'h0001, 32'd0, 1'b0};
    steps[1] = '{1'b0, 3, 0, 1'b1, 26'd5, 1'b0, 16'h0000, 32'd8, 1'b0};
    steps[2] = '{1'b0, 0, 4, 1'b0, 26'd0, 1'b0, 16'h0000, 32'd20, 1'b0};
    steps[3] = '{1'b0, 1, 1, 1'b0, 26'd0, 1'b1, 16'h0001, 32'd24, 1'b0};
    steps[4] = '{1'b0, 0, 0, 1'b0, 26'd0, 1'b0, 16'h0000, 32'd32, 1'b1};
    steps[5] = '{1'b1, 0, 0, 1'b1, 26'd7, 1'b0, 16'h0000, 32'd0, 1'b0};
    steps[6] = '{1'b0, 2, 0, 1'b1, 26'd8, 1'b1, 16'hFFFF, 32'd28, 1'b0};
    steps[7] = '{1'b0, 0, 2, 1'b0, 26'd0, 1'b1, 16'hFFFE, 32'd32, 1'b0};
    steps[8] = '{1'b0, 0, 0, 1'b0, 26'd0, 1'b0, 16'h0000, 32'd28, 1'b0};
    steps[9] = '{1'b0, 0, 0, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0000, 32'd32, 1'b1};
    ret = 0;
    foreach (steps[k]) begin
      if (steps[k].restart) begin
        do_start();
        ret = 0;
      end
      rd = $urandom;
      serve_fetch(steps[k].ack_lat, rd, steps[k].exp_addr);
      ret++;
      accept(steps[k].rdy_lat, steps[k].j, steps[k].tgt, steps[k].br, steps[k].off, rd,
             steps[k].exp_addr, steps[k].exp_done, ret);
    end

    // Reset while fetching at 12; a late ack must be ignored.
    do_start();
    for (int i = 0; i < 3; i++) begin
      rd = $urandom;
      serve_fetch(0, rd, 32'(i * 4));
      accept(0, 1'b0, '0, 1'b0, '0, rd, 32'(i * 4), 1'b0, i + 1);
    end
    chk("pre_rst_addr", imem_addr, 32'd12);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    tick();
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_instr", instr_out, 32'd0);
    do_start();
    rd = $urandom;
    serve_fetch(0, rd, 32'd0);
    accept(0, 1'b0, '0, 1'b0, '0, rd, 32'd0, 1'b0, 1);

    // Backward branch from 0 wraps above LAST_PC; then restart from DONE.
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_start();
    rd = $urandom;
    serve_fetch(0, rd, 32'd0);
    accept(0, 1'b0, '0, 1'b1, 16'hFFFE, rd, 32'd0, 1'b1, 1);
    tick();
    chk("wrap_done_hold", 32'(done), 32'd1);
    chk("wrap_retired_hold", 32'(retired), 32'd1);
    do_start();
    rd = $urandom;
    serve_fetch(1, rd, 32'd0);
    accept(1, 1'b0, '0, 1'b0, '0, rd, 32'd0, 1'b0, 1);

    // Random programs against the reference model.
    for (int p = 0; p < 12; p++) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      do_start();
      pc  = 32'd0;
      ret = 0;
      fin = 1'b0;
      for (int s = 0; s < 30 && !fin; s++) begin
        bit          j;
        bit          br;
        logic [25:0] tgt;
        logic [15:0] off;
        int          o;
        j   = ($urandom_range(0, 5) == 0);
        br  = ($urandom_range(0, 2) == 0);
        tgt = 26'($urandom_range(0, 10));
        o   = int'($urandom_range(0, 8)) - 4;
        off = o[15:0];
        rd  = $urandom;
        serve_fetch(int'($urandom_range(0, 3)), rd, pc);
        ret++;
        fin = model_next(pc, j, tgt, br, off, nxt);
        accept(int'($urandom_range(0, 3)), j, tgt, br, off, rd, pc, fin, ret);
        if (!fin) begin
          pc = nxt;
          chk("rand_next_addr", imem_addr, pc);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
